// File: rtl/led_press_ctrl.sv
// Push-button front end: synchronises and debounces A, and turns each clean press into an
// ODD/EVEN step whose LED pattern comes from a bounded LFSR search for the required parity.
module led_press_ctrl #(
  parameter int          N_LEDS       = 10,
  parameter int          DEBOUNCE_CYC = 4,
  parameter logic [15:0] SEED         = 16'hACE1,
  parameter int          GEN_MAX      = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              A,
  output logic [N_LEDS-1:0] LED,
  output logic [1:0]        state_o,
  output logic              busy,
  output logic [7:0]        press_cnt,
  output logic              press_drop
);

  localparam int DB_W  = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int GEN_W = (GEN_MAX > 1) ? $clog2(GEN_MAX) : 1;
  localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [GEN_W-1:0]  GEN_LAST = GEN_W'(GEN_MAX - 1);
  localparam logic [N_LEDS-1:0] LSB_MASK = N_LEDS'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_ODD  = 2'b01,
    S_EVEN = 2'b10,
    S_GEN  = 2'b11
  } state_t;

  logic              a_s1_q, a_s1_d;
  logic              a_sync_q, a_sync_d;
  logic              a_db_q, a_db_d;
  logic              a_db_d1_q, a_db_d1_d;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  state_t            state_q, state_d;
  state_t            ret_q, ret_d;
  logic              tgt_q, tgt_d;
  logic [15:0]       lfsr_q, lfsr_d;
  logic [GEN_W-1:0]  gen_cnt_q, gen_cnt_d;
  logic [N_LEDS-1:0] led_q, led_d;
  logic [7:0]        press_cnt_q, press_cnt_d;
  logic              press;
  logic [15:0]       lfsr_next;
  logic [N_LEDS-1:0] cand;

  // Debounced level only follows a_sync after DEBOUNCE_CYC consecutive disagreeing cycles.
  always_comb begin
    a_s1_d    = A;
    a_sync_d  = a_s1_q;
    a_db_d1_d = a_db_q;
    a_db_d    = a_db_q;
    db_cnt_d  = '0;
    if (a_sync_q != a_db_q) begin
      if (db_cnt_q == DB_LAST) begin
        a_db_d = a_sync_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  assign press     = a_db_q & ~a_db_d1_q;
  assign lfsr_next = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign cand      = lfsr_next[N_LEDS-1:0];

  always_comb begin
    state_d     = state_q;
    ret_d       = ret_q;
    tgt_d       = tgt_q;
    lfsr_d      = lfsr_q;
    gen_cnt_d   = gen_cnt_q;
    led_d       = led_q;
    press_cnt_d = press_cnt_q;
    press_drop  = 1'b0;
    case (state_q)
      S_IDLE, S_EVEN: begin
        if (press) begin
          tgt_d       = 1'b1;
          ret_d       = S_ODD;
          state_d     = S_GEN;
          gen_cnt_d   = '0;
          press_cnt_d = press_cnt_q + 8'd1;
        end
      end
      S_ODD: begin
        if (press) begin
          tgt_d       = 1'b0;
          ret_d       = S_EVEN;
          state_d     = S_GEN;
          gen_cnt_d   = '0;
          press_cnt_d = press_cnt_q + 8'd1;
        end
      end
      S_GEN: begin
        // Presses are never queued while searching, including on the exit cycle.
        press_drop = press;
        lfsr_d     = lfsr_next;
        if ((^cand) == tgt_q) begin
          led_d   = cand;
          state_d = ret_q;
        end else if (gen_cnt_q == GEN_LAST) begin
          led_d   = cand ^ LSB_MASK;
          state_d = ret_q;
        end else begin
          gen_cnt_d = gen_cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_s1_q      <= 1'b0;
      a_sync_q    <= 1'b0;
      a_db_q      <= 1'b0;
      a_db_d1_q   <= 1'b0;
      db_cnt_q    <= '0;
      state_q     <= S_IDLE;
      ret_q       <= S_ODD;
      tgt_q       <= 1'b1;
      lfsr_q      <= SEED;
      gen_cnt_q   <= '0;
      led_q       <= '0;
      press_cnt_q <= 8'd0;
    end else begin
      a_s1_q      <= a_s1_d;
      a_sync_q    <= a_sync_d;
      a_db_q      <= a_db_d;
      a_db_d1_q   <= a_db_d1_d;
      db_cnt_q    <= db_cnt_d;
      state_q     <= state_d;
      ret_q       <= ret_d;
      tgt_q       <= tgt_d;
      lfsr_q      <= lfsr_d;
      gen_cnt_q   <= gen_cnt_d;
      led_q       <= led_d;
      press_cnt_q <= press_cnt_d;
    end
  end

  assign LED       = led_q;
  assign state_o   = state_q;
  assign busy      = (state_q == S_GEN);
  assign press_cnt = press_cnt_q;

endmodule

// File: tb/tb_led_press_ctrl.sv
// Bench for led_press_ctrl: default instance checked against an LFSR search model, plus a
// forced-parity instance (GEN_MAX=1) and a fast-debounce instance for drop/abort cases.
module tb_led_press_ctrl;

  logic       clk = 1'b0;
  logic       rst0, rst1, rst2;
  logic       a0, a1, a2;
  logic [9:0] led0, led1;
  logic [0:0] led2;
  logic [1:0] st0, st1, st2;
  logic       busy0, busy1, busy2;
  logic [7:0] cnt0, cnt1, cnt2;
  logic       drop0, drop1, drop2;

  int checks   = 0;
  int failures = 0;

  logic [15:0] m_lfsr;

  typedef struct {
    int         highCyc;
    int         lowCyc;
    logic [1:0] expState;
    logic [7:0] expCnt;
  } vec_t;

  vec_t vecs[5];

  always #5 clk = ~clk;

  led_press_ctrl dut (
    .clk(clk), .reset(rst0), .A(a0), .LED(led0), .state_o(st0), .busy(busy0),
    .press_cnt(cnt0), .press_drop(drop0)
  );

  led_press_ctrl #(.N_LEDS(10), .DEBOUNCE_CYC(4), .SEED(16'h0003), .GEN_MAX(1)) dut_f (
    .clk(clk), .reset(rst1), .A(a1), .LED(led1), .state_o(st1), .busy(busy1),
    .press_cnt(cnt1), .press_drop(drop1)
  );

  led_press_ctrl #(.N_LEDS(1), .DEBOUNCE_CYC(1), .SEED(16'h0001), .GEN_MAX(8)) dut_d (
    .clk(clk), .reset(rst2), .A(a2), .LED(led2), .state_o(st2), .busy(busy2),
    .press_cnt(cnt2), .press_drop(drop2)
  );

  function automatic logic [15:0] lfsrStep(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  // Reference search for the default instance (10 LEDs, up to 8 steps).
  task automatic modelSearch(input logic tgt, output logic [9:0] led, output int steps);
    logic [9:0] p;
    p     = '0;
    led   = '0;
    steps = 0;
    for (int s = 1; s <= 8; s++) begin
      m_lfsr = lfsrStep(m_lfsr);
      p      = m_lfsr[9:0];
      if ((^p) == tgt) begin
        led   = p;
        steps = s;
        break;
      end
    end
    if (steps == 0) begin
      steps = 8;
      led   = {p[9:1], ~p[0]};
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic driveA(input int idx, input logic v);
    case (idx)
      0:       a0 = v;
      1:       a1 = v;
      default: a2 = v;
    endcase
  endtask

  function automatic logic busyOf(input int idx);
    return (idx == 0) ? busy0 : (idx == 1) ? busy1 : busy2;
  endfunction

  function automatic logic dropOf(input int idx);
    return (idx == 0) ? drop0 : (idx == 1) ? drop1 : drop2;
  endfunction

  // Drives a level pattern on one instance's A and counts busy / press_drop cycles.
  task automatic applyStimulus(input int idx, input int highCyc, input int lowCyc,
                               output int busyCyc, output int dropCyc);
    busyCyc = 0;
    dropCyc = 0;
    for (int i = 0; i < highCyc + lowCyc; i++) begin
      driveA(idx, i < highCyc);
      @(negedge clk);
      if (busyOf(idx)) busyCyc++;
      if (dropOf(idx)) dropCyc++;
    end
    for (int w = 0; w < 40 && busyOf(idx); w++) begin
      @(negedge clk);
      if (busyOf(idx)) busyCyc++;
      if (dropOf(idx)) dropCyc++;
    end
    if (busyOf(idx)) checkOutput("gen_timeout", 32'(busyOf(idx)), 32'd0);
  endtask

  initial begin
    int         busyCyc, dropCyc, stepsExp;
    logic [9:0] ledExp;

    vecs[0] = '{10, 12, 2'b01, 8'd1};
    vecs[1] = '{10, 12, 2'b10, 8'd2};
    vecs[2] = '{8,  14, 2'b01, 8'd3};
    vecs[3] = '{12, 10, 2'b10, 8'd4};
    vecs[4] = '{10, 12, 2'b01, 8'd5};

    a0 = 1'b0; a1 = 1'b0; a2 = 1'b0;
    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
    repeat (2) @(negedge clk);
    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;

    // Reset and idle: nothing moves, LFSR holds its seed.
    repeat (20) @(negedge clk);
    checkOutput("reset_led", 32'(led0), 32'd0);
    checkOutput("reset_state", 32'(st0), 32'd0);
    checkOutput("reset_cnt", 32'(cnt0), 32'd0);
    checkOutput("reset_busy", 32'(busy0), 32'd0);
    checkOutput("reset_drop", 32'(drop0), 32'd0);
    checkOutput("reset_lfsr", 32'(dut.lfsr_q), 32'hACE1);
    checkOutput("reset_state_f", 32'(st1), 32'd0);
    checkOutput("reset_state_d", 32'(st2), 32'd0);

    // Bounce: toggling every cycle never survives the debounce window.
    busyCyc = 0;
    for (int i = 0; i < 40; i++) begin
      a0 = (i < 30) ? i[0] : 1'b0;
      @(negedge clk);
      if (busy0) busyCyc++;
    end
    checkOutput("bounce_busy", 32'(busyCyc), 32'd0);
    checkOutput("bounce_state", 32'(st0), 32'd0);
    checkOutput("bounce_cnt", 32'(cnt0), 32'd0);

    // Clean presses from IDLE: ODD, EVEN, ODD, EVEN, ODD.
    m_lfsr = 16'hACE1;
    for (int v = 0; v < 5; v++) begin
      modelSearch(vecs[v].expState == 2'b01, ledExp, stepsExp);
      applyStimulus(0, vecs[v].highCyc, vecs[v].lowCyc, busyCyc, dropCyc);
      checkOutput($sformatf("vec%0d_state", v), 32'(st0), 32'(vecs[v].expState));
      checkOutput($sformatf("vec%0d_cnt", v), 32'(cnt0), 32'(vecs[v].expCnt));
      checkOutput($sformatf("vec%0d_led", v), 32'(led0), 32'(ledExp));
      checkOutput($sformatf("vec%0d_parity", v), 32'(^led0), 32'(vecs[v].expState == 2'b01));
      checkOutput($sformatf("vec%0d_gen_cycles", v), 32'(busyCyc), 32'(stepsExp));
      checkOutput($sformatf("vec%0d_drop", v), 32'(dropCyc), 32'd0);
    end

    // GEN_MAX=1, seed 0003: first step gives 0x006 (even), so bit0 is forced -> 0x007.
    applyStimulus(1, 10, 12, busyCyc, dropCyc);
    checkOutput("forced_gen_cycles", 32'(busyCyc), 32'd1);
    checkOutput("forced_led", 32'(led1), 32'h007);
    checkOutput("forced_state", 32'(st1), 32'd1);
    checkOutput("forced_cnt", 32'(cnt1), 32'd1);

    // Fast debounce, 1 LED, seed 0001: search exhausts 8 steps; a second press lands in GEN.
    busyCyc = 0;
    dropCyc = 0;
    for (int i = 0; i < 24; i++) begin
      a2 = (i < 2) || (i == 4) || (i == 5);
      @(negedge clk);
      if (busy2) busyCyc++;
      if (drop2) dropCyc++;
    end
    checkOutput("drop_pulses", 32'(dropCyc), 32'd1);
    checkOutput("drop_gen_cycles", 32'(busyCyc), 32'd8);
    checkOutput("drop_cnt", 32'(cnt2), 32'd1);
    checkOutput("drop_state", 32'(st2), 32'd1);
    checkOutput("drop_led", 32'(led2), 32'd1);

    // Reset from ODD clears LED, then a reset mid-search commits nothing.
    rst2 = 1'b1;
    @(negedge clk);
    rst2 = 1'b0;
    checkOutput("rst_led", 32'(led2), 32'd0);
    checkOutput("rst_state", 32'(st2), 32'd0);
    a2 = 1'b1;
    for (int w = 0; w < 20 && !busy2; w++) @(negedge clk);
    checkOutput("abort_entered_gen", 32'(busy2), 32'd1);
    a2 = 1'b0;
    repeat (3) @(negedge clk);
    rst2 = 1'b1;
    @(negedge clk);
    rst2 = 1'b0;
    checkOutput("abort_state", 32'(st2), 32'd0);
    checkOutput("abort_led", 32'(led2), 32'd0);
    checkOutput("abort_cnt", 32'(cnt2), 32'd0);
    repeat (12) @(negedge clk);
    checkOutput("abort_hold_state", 32'(st2), 32'd0);
    checkOutput("abort_hold_led", 32'(led2), 32'd0);
    applyStimulus(2, 2, 14, busyCyc, dropCyc);
    checkOutput("after_abort_gen_cycles", 32'(busyCyc), 32'd8);
    checkOutput("after_abort_led", 32'(led2), 32'd1);

    // 256 presses wrap the counter; an even count ends in EVEN.
    rst0 = 1'b1;
    @(negedge clk);
    rst0 = 1'b0;
    for (int n = 1; n <= 256; n++) begin
      applyStimulus(0, 8, 10, busyCyc, dropCyc);
      if (n == 255) checkOutput("wrap_cnt255", 32'(cnt0), 32'd255);
    end
    checkOutput("wrap_cnt0", 32'(cnt0), 32'd0);
    checkOutput("wrap_state", 32'(st0), 32'd2);
    checkOutput("wrap_parity", 32'(^led0), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
